// File: rtl/uart_receiver.sv
// uart_receiver
//   8N1 UART receiver: 1 start bit, 8 data bits LSB-first, 1 stop bit, idle-high line.
//   The line is oversampled on clock_enable ticks and every bit is sampled at mid-bit.
//   Received bytes are offered on a valid/ready handshake. Framing errors and overruns
//   are reported as single-cycle pulses.
//
//   Build option: UART_RX_SYNC_EN
//     defined   - rx passes through a 2-flop synchroniser before the FSM (2 cycles of latency)
//     undefined - rx is used directly and must already be synchronous to CLKIN
//
//   Ports
//     CLKIN          in   clock; all state updates on posedge
//     RESETN         in   asynchronous active-low reset
//     clock_enable   in   oversample tick; bit timing advances only when high
//     rx             in   serial line, idle high
//     data[7:0]      out  received byte, stable while valid is high
//     valid          out  byte available, held until accepted
//     ready          in   consumer accepts data on a posedge with valid && ready
//     framing_error  out  1-cycle pulse: stop bit sampled low
//     overrun        out  1-cycle pulse: new byte dropped, previous still unaccepted
//     busy           out  high whenever the FSM is not in IDLE
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | line idle, waiting for a low level (start edge)
//   START | counting to mid start bit, then confirming it is still low
//   DATA  | sampling 8 data bits, one every OVERSAMPLE ticks
//   STOP  | sampling the stop bit; delivers the byte or flags framing error
//   BREAK | stop bit was low; waiting for the line to return high

module uart_receiver #(
    parameter int OVERSAMPLE = 4
) (
    input  logic       CLKIN,
    input  logic       RESETN,
    input  logic       clock_enable,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       framing_error,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF = OVERSAMPLE / 2;
    localparam int CW   = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    data_sh;
    logic          rx_s;

`ifdef UART_RX_SYNC_EN
    logic [1:0] rx_sync;

    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], rx};
        end
    end

    assign rx_s = rx_sync[1];
`else
    assign rx_s = rx;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= 3'd0;
            data_sh       <= 8'h00;
            data          <= 8'h00;
            valid         <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            overrun       <= 1'b0;

            // Handshake runs at full clock rate; a delivery below overrides this.
            if (valid && ready) begin
                valid <= 1'b0;
            end

            if (clock_enable) begin
                unique case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state <= START;
                            cnt   <= '0;
                        end
                    end
                    START: begin
                        if (cnt == CNT_HALF) begin
                            cnt   <= '0;
                            idx   <= 3'd0;
                            // Line back high at mid start bit: treat as a glitch.
                            state <= rx_s ? IDLE : DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (cnt == CNT_LAST) begin
                            cnt          <= '0;
                            data_sh[idx] <= rx_s;
                            if (idx == 3'd7) begin
                                state <= STOP;
                            end else begin
                                idx <= idx + 3'd1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (cnt == CNT_LAST) begin
                            cnt <= '0;
                            if (rx_s) begin
                                state <= IDLE;
                                // Holding register is free if empty or being drained on this edge.
                                if (!valid || ready) begin
                                    data  <= data_sh;
                                    valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                framing_error <= 1'b1;
                                state         <= BREAK;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    BREAK: begin
                        if (rx_s) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
